alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//  Registered writeback stage directly downstream of the 16-bit ALU. Captures
//  the ALU result Z and its flags (carry, sign, overflow, parity, zero) into a
//  2-entry skid buffer with valid/ready handshakes on both sides.
//  Also keeps a sticky overflow flag and a wrapping count of accepted results.
// PARAMETERS
//  DATA_W  16  result width; must match the ALU Z width
//  CNT_W   8   width of the accepted-result counter
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  rst_n       in   1       asynchronous active-low reset
//  in_valid    in   1       ALU result and flags valid this cycle
//  in_ready    out  1       stage can accept; registered, no path from out_ready
//  in_z        in   DATA_W  ALU result Z
//  in_carry    in   1       ALU carry
//  in_sign     in   1       ALU sign
//  in_overflow in   1       ALU overflow
//  in_parity   in   1       ALU parity (1 = even number of ones in Z)
//  in_zero     in   1       ALU zero
//  out_valid   out  1       head entry valid
//  out_ready   in   1       consumer accepts the head entry
//  out_z       out  DATA_W  head result
//  out_flags   out  5       head flags {zero,parity,overflow,sign,carry} = [4:0]
//  sticky_ovf  out  1       set by any accepted entry with overflow=1
//  clr_sticky  in   1       synchronous clear of sticky_ovf
//  acc_count   out  CNT_W   number of accepted inputs, modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (rst_n=0, async): occupancy=0, out_valid=0, in_ready=1, out_z=0,
//    out_flags=0, sticky_ovf=0, acc_count=0. Entry storage is cleared.
//    Reset mid-transfer discards all held entries.
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - Occupancy states: EMPTY(0), ONE(1), FULL(2). in_ready = (occ != FULL),
//    derived from registered state only.
//  - Latency: an input pushed in cycle N appears on out_* with out_valid=1 in
//    cycle N+1. The stage has no combinational bypass.
//  - Order is strict FIFO. out_z/out_flags come from the head entry and hold
//    stable while out_valid=1 and out_ready=0.
//  - Transitions:
//    - EMPTY + push -> ONE
//    - ONE + push & !pop -> FULL
//    - ONE + push & pop -> ONE (new entry becomes the head)
//    - ONE + pop & !push -> EMPTY
//    - FULL + pop -> ONE (second entry moves to the head)
//    - FULL + push cannot occur because in_ready=0.
//  - Full throughput: with out_ready held at 1, the stage accepts one input
//    per cycle and never deasserts in_ready.
//  - When out_valid=0, out_z/out_flags keep the last popped value.
//    The consumer must ignore them.
//  - in_* values are ignored when push=0.
//  - sticky_ovf: the next value is 1 if push & in_overflow. Otherwise it is 0
//    if clr_sticky. Otherwise it holds. If set and clear occur in the same
//    cycle, set wins.
//  - acc_count increments by 1 on each push and wraps from 2^CNT_W-1 to 0.
//    It is not affected by pop.
//  - Flags are passed through unmodified. The stage does no arithmetic on Z.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream with occ=2 -> same cycle: out_valid=0,
//     in_ready=1, acc_count=0, sticky_ovf=0.
//  T2 single: push Z=16'h8000, flags=5'b00110, out_ready=1 -> next cycle
//     out_valid=1, out_z=16'h8000, out_flags=5'b00110, acc_count=1; then
//     out_valid=0.
//  T3 backpressure: out_ready=0, push 16'h0001, 16'h0002 -> in_ready=0 after
//     the second push and out_z=16'h0001 holds; raise out_ready -> 0001 then
//     0002 in order, in_ready=1 after the first pop.
//  T4 streaming: out_ready=1, push 16'h0000..16'h0009 back-to-back -> in_ready
//     stays 1, outputs appear in order one cycle later, acc_count=10.
//  T5 sticky: push an entry with overflow=1 while clr_sticky=1 -> sticky_ovf=1;
//     next cycle clr_sticky=1 with no push -> sticky_ovf=0.
//  T6 wrap: with CNT_W=8, 256 pushes -> acc_count=0; the 257th push -> 1.

Source files
------------

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered writeback stage behind the 16-bit ALU. Each ALU result Z and
//   its five flags are captured into a 2-entry skid buffer with valid/ready
//   handshakes on both sides. in_ready comes only from registered occupancy,
//   so there is no combinational path from out_ready back to in_ready.
//   The stage also keeps a sticky overflow flag and a wrapping count of
//   accepted results.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     upstream handshake
//   in_z, in_carry, in_sign, in_overflow, in_parity, in_zero
//                           ALU result and flags
//   out_valid / out_ready   downstream handshake
//   out_z, out_flags        head entry; flags = {zero,parity,overflow,sign,carry}
//   sticky_ovf, clr_sticky  sticky overflow and its synchronous clear
//   acc_count               accepted inputs, modulo 2^CNT_W
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_z,
  input  logic              in_carry,
  input  logic              in_sign,
  input  logic              in_overflow,
  input  logic              in_parity,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_z,
  output logic [4:0]        out_flags,
  output logic              sticky_ovf,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  acc_count
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [DATA_W-1:0] z;
    logic [4:0]        flags;
  } entry_t;

  occ_e             occ_q, occ_d;
  entry_t           head_q, head_d;   // drives out_*
  entry_t           tail_q, tail_d;   // second entry, only meaningful when FULL
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  entry_t in_entry;
  logic   push, pop;

  assign in_entry = '{z: in_z,
                      flags: {in_zero, in_parity, in_overflow, in_sign, in_carry}};

  assign in_ready  = (occ_q != OCC_FULL);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_z      = head_q.z;
  assign out_flags  = head_q.flags;
  assign sticky_ovf = sticky_q;
  assign acc_count  = cnt_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;

    unique case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          head_d = in_entry;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push && pop) begin
          head_d = in_entry;          // old head leaves, new entry takes its place
        end else if (push) begin
          tail_d = in_entry;
          occ_d  = OCC_FULL;
        end else if (pop) begin
          occ_d  = OCC_EMPTY;         // head keeps the last popped value
        end
      end
      OCC_FULL: begin
        // push is impossible here since in_ready=0
        if (pop) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase

    // Set has priority over clear.
    if (push && in_overflow) sticky_d = 1'b1;
    else if (clr_sticky)     sticky_d = 1'b0;
    else                     sticky_d = sticky_q;

    cnt_d = push ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= OCC_EMPTY;
      // NOTE: the entry storage is reset too, so out_z/out_flags read zero
      // after reset instead of stale data from before it.
      head_q   <= '0;
      tail_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//   Self-checking bench for alu_result_stage. A hand-derived vector table
//   covers single transfer, backpressure and sticky overflow; directed
//   sequences cover reset while full, streaming and counter wrap; random
//   traffic is compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] in_z;
  logic              in_carry, in_sign, in_overflow, in_parity, in_zero;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_z;
  logic [4:0]        out_flags;
  logic              sticky_ovf, clr_sticky;
  logic [CNT_W-1:0]  acc_count;

  alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_carry(in_carry), .in_sign(in_sign),
    .in_overflow(in_overflow), .in_parity(in_parity), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky),
    .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of at most two entries.
  typedef struct {
    logic [15:0] z;
    logic [4:0]  f;
  } ent_t;

  ent_t m_q[$];
  ent_t m_last;      // value the head shows when empty
  bit   m_sticky;
  int   m_cnt;

  function automatic void model_reset();
    m_q.delete();
    m_last   = '{z: '0, f: '0};
    m_sticky = 1'b0;
    m_cnt    = 0;
  endfunction

  task automatic check_model(input string tag);
    ent_t h;
    h = (m_q.size() > 0) ? m_q[0] : m_last;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_q.size() < 2));
    check({tag, ".out_z"},     32'(out_z),     32'(h.z));
    check({tag, ".out_flags"}, 32'(out_flags), 32'(h.f));
    check({tag, ".sticky"},    32'(sticky_ovf), 32'(m_sticky));
    check({tag, ".acc_count"}, 32'(acc_count), 32'(m_cnt % (1 << CNT_W)));
  endtask

  // One clock: drive inputs (caller sits between negedge and posedge),
  // advance the model at the rising edge, compare at the falling edge.
  task automatic cycle(input bit iv, input bit ordy, input logic [15:0] z,
                       input logic [4:0] fl, input bit clr, input string tag);
    bit push, pop;
    ent_t e;
    in_valid    = iv;
    out_ready   = ordy;
    in_z        = z;
    {in_zero, in_parity, in_overflow, in_sign, in_carry} = fl;
    clr_sticky  = clr;
    @(posedge clk);
    push = iv && (m_q.size() < 2);
    pop  = ordy && (m_q.size() > 0);
    if (pop) m_last = m_q.pop_front();
    if (push) begin
      e = '{z: z, f: fl};
      m_q.push_back(e);
      m_cnt++;
    end
    if (push && fl[2]) m_sticky = 1'b1;
    else if (clr)      m_sticky = 1'b0;
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    bit          iv, ordy, clr;
    logic [15:0] z;
    logic [4:0]  fl;
    bit          e_ov, e_ir, e_st;
    logic [15:0] e_z;
    logic [4:0]  e_fl;
    int          e_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // iv ordy clr   z        fl        | ov ir st  z        fl        cnt
    vecs[0] = '{1, 1, 0, 16'h8000, 5'b00110, 1, 1, 1, 16'h8000, 5'b00110, 1}; // single push
    vecs[1] = '{0, 1, 0, 16'h0000, 5'b00000, 0, 1, 1, 16'h8000, 5'b00110, 1}; // pop, head holds
    vecs[2] = '{1, 0, 1, 16'h0001, 5'b00000, 1, 1, 0, 16'h0001, 5'b00000, 2}; // stall, clear sticky
    vecs[3] = '{1, 0, 0, 16'h0002, 5'b00001, 1, 0, 0, 16'h0001, 5'b00000, 3}; // now full
    vecs[4] = '{1, 0, 0, 16'h0003, 5'b00100, 1, 0, 0, 16'h0001, 5'b00000, 3}; // refused push
    vecs[5] = '{0, 1, 0, 16'h0000, 5'b00000, 1, 1, 0, 16'h0002, 5'b00001, 3}; // pop 0001
    vecs[6] = '{0, 1, 0, 16'h0000, 5'b00000, 0, 1, 0, 16'h0002, 5'b00001, 3}; // pop 0002
    vecs[7] = '{1, 1, 1, 16'h1234, 5'b00100, 1, 1, 1, 16'h1234, 5'b00100, 4}; // set beats clear
    vecs[8] = '{0, 1, 1, 16'h0000, 5'b00000, 0, 1, 0, 16'h1234, 5'b00100, 4}; // clear alone

    rst_n = 1'b0;
    {in_valid, out_ready, clr_sticky} = '0;
    in_z = '0;
    {in_zero, in_parity, in_overflow, in_sign, in_carry} = '0;
    model_reset();
    @(negedge clk);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready",  32'(in_ready),  32'd1);
    check("reset.out_z",     32'(out_z),     32'd0);
    check("reset.out_flags", 32'(out_flags), 32'd0);
    #2 rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].iv, vecs[i].ordy, vecs[i].z, vecs[i].fl, vecs[i].clr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_ov", i),  32'(out_valid),  32'(vecs[i].e_ov));
      check($sformatf("vec%0d.tbl_ir", i),  32'(in_ready),   32'(vecs[i].e_ir));
      check($sformatf("vec%0d.tbl_z", i),   32'(out_z),      32'(vecs[i].e_z));
      check($sformatf("vec%0d.tbl_fl", i),  32'(out_flags),  32'(vecs[i].e_fl));
      check($sformatf("vec%0d.tbl_st", i),  32'(sticky_ovf), 32'(vecs[i].e_st));
      check($sformatf("vec%0d.tbl_cnt", i), 32'(acc_count),  32'(vecs[i].e_cnt));
    end

    // Streaming: ten back-to-back pushes with out_ready held high
    #2 rst_n = 1'b0;
    #1 model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 16'(i), 5'(i), 0, "stream");
      check("stream.in_ready", 32'(in_ready), 32'd1);
      check("stream.z",        32'(out_z),    32'(i));
    end
    check("stream.count", 32'(acc_count), 32'd10);
    cycle(0, 1, 16'h0, 5'h0, 0, "stream_drain");

    // Reset while full and sticky set
    cycle(1, 0, 16'hAAAA, 5'b00100, 0, "prefill");
    cycle(1, 0, 16'h5555, 5'b00000, 0, "prefill");
    check("prefill.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", 32'(out_valid),  32'd0);
    check("midreset.in_ready",  32'(in_ready),   32'd1);
    check("midreset.acc_count", 32'(acc_count),  32'd0);
    check("midreset.sticky",    32'(sticky_ovf), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    cycle(0, 1, 16'h0, 5'h0, 0, "post_reset_idle");

    // Counter wrap
    for (int i = 0; i < 256; i++) cycle(1, 1, 16'($urandom), 5'b00000, 0, "wrap");
    check("wrap.256", 32'(acc_count), 32'd0);
    cycle(1, 1, 16'h0BAD, 5'b00000, 0, "wrap257");
    check("wrap.257", 32'(acc_count), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            16'($urandom), 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
